// File: rtl/sata_rx_crc32_check_pkg.sv
// rtl/sata_rx_crc32_check_pkg.sv - SATA CRC32 constants, types and single-dword step function
//
// Purpose: shared definitions for the SATA receive-side CRC32 checker.
//   CRC_POLY   : generator polynomial 0x04C11DB7 (x^32 term implicit)
//   CRC_SEED   : SATA CRC initial value 0x52325032
//   crc32_step : advances the CRC by one 32-bit dword, MSB first,
//                with no reflection and no final XOR
package sata_crc_pkg;

  typedef logic [31:0] dword_t;
  typedef logic [15:0] count_t;

  localparam dword_t CRC_POLY = 32'h04C1_1DB7;
  localparam dword_t CRC_SEED = 32'h5232_5032;
  localparam count_t CNT_MAX  = 16'hFFFF;

  // Bit-serial LFSR unrolled over one dword. Feeding data into the
  // feedback tap makes this equal to ((crc ^ data) * x^32) mod P.
  function automatic dword_t crc32_step(input dword_t crc, input dword_t data);
    dword_t c;
    logic   fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_rx_crc32_check_if.sv
// rtl/sata_rx_crc32_check_if.sv - dword stream and CRC status bundle for the CRC32 checker
//
// Purpose: groups the frame input stream and the CRC status outputs.
//   crc_rst    : start-of-frame pulse, re-seeds the CRC
//   data_in    : descrambled frame dword (payload followed by CRC dword)
//   data_valid : data_in qualifier
//   err_inject : arm fault injection (SATA_RX_CRC_FAKE_ERR_EN builds only)
//   crc_out    : running CRC of dwords accepted since crc_rst
//   crc_ok     : last accepted dword equalled the CRC of the dwords before it
//   crc_rdy    : at least one dword accepted since crc_rst
//   dword_cnt  : dwords accepted since crc_rst, saturating
//   err_ack    : one-cycle acknowledge of an injection arm
// Modports: master drives the stream, slave is the checker.
interface sata_rx_crc32_check_if;
  import sata_crc_pkg::*;

  logic   crc_rst;
  dword_t data_in;
  logic   data_valid;
  logic   err_inject;
  dword_t crc_out;
  logic   crc_ok;
  logic   crc_rdy;
  count_t dword_cnt;
  logic   err_ack;

  modport master (
    output crc_rst, data_in, data_valid, err_inject,
    input  crc_out, crc_ok, crc_rdy, dword_cnt, err_ack
  );

  modport slave (
    input  crc_rst, data_in, data_valid, err_inject,
    output crc_out, crc_ok, crc_rdy, dword_cnt, err_ack
  );

endinterface

// File: rtl/sata_crc32_next.sv
// rtl/sata_crc32_next.sv - combinational one-dword SATA CRC32 advance
//
// Purpose: next-state CRC for one dword.
// Ports:
//   crc      : in,  32 bits, current CRC
//   data     : in,  32 bits, dword to absorb
//   crc_next : out, 32 bits, CRC after absorbing data
module sata_crc32_next
  import sata_crc_pkg::*;
(
  input  dword_t crc,
  input  dword_t data,
  output dword_t crc_next
);

  assign crc_next = crc32_step(crc, data);

endmodule

// File: rtl/sata_rx_crc32_check.sv
// rtl/sata_rx_crc32_check.sv - SATA receive CRC32 checker with optional fault injection
//
// Purpose: runs the SATA CRC32 over each accepted frame dword and flags when
// the latest dword equals the CRC of everything before it, so that at end of
// frame crc_ok reports whether the received CRC dword was correct.
// Optional feature macro: SATA_RX_CRC_FAKE_ERR_EN (fault injection).
// Ports:
//   clk_75m    : in, single rising-edge clock
//   host_rst_n : in, synchronous active-low reset
//   bus        : sata_rx_crc32_check_if.slave, stream in / status out
module sata_rx_crc32_check
  import sata_crc_pkg::*;
(
  input logic                        clk_75m,
  input logic                        host_rst_n,
  sata_rx_crc32_check_if.slave       bus
);

  dword_t r_crc;
  logic   r_ok;
  logic   r_rdy;
  count_t r_cnt;
  logic   r_err_ack;
  logic   r_armed;
  dword_t w_crc_next;
  logic   w_accept;
  logic   w_match;

  // crc_rst has priority: a dword arriving with it is dropped.
  assign w_accept = bus.data_valid & ~bus.crc_rst;
  assign w_match  = (r_crc == bus.data_in);

  sata_crc32_next u_next (
    .crc      (r_crc),
    .data     (bus.data_in),
    .crc_next (w_crc_next)
  );

  always_ff @(posedge clk_75m) begin
    if (!host_rst_n) begin
      r_crc <= CRC_SEED;
      r_ok  <= 1'b0;
      r_rdy <= 1'b0;
      r_cnt <= '0;
    end else if (bus.crc_rst) begin
      r_crc <= CRC_SEED;
      r_ok  <= 1'b0;
      r_rdy <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_crc <= w_crc_next;
      // Compare against the CRC before this dword, so the CRC dword
      // itself is checked against the payload CRC.
      r_ok  <= w_match & ~r_armed;
      r_rdy <= 1'b1;
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef SATA_RX_CRC_FAKE_ERR_EN
  // Arm is sampled only at crc_rst, so it lasts for exactly one frame
  // unless the next crc_rst re-arms it.
  always_ff @(posedge clk_75m) begin
    if (!host_rst_n) begin
      r_armed   <= 1'b0;
      r_err_ack <= 1'b0;
    end else if (bus.crc_rst) begin
      r_armed   <= bus.err_inject;
      r_err_ack <= bus.err_inject;
    end else begin
      r_err_ack <= 1'b0;
    end
  end
`else
  logic w_unused_err_inject;
  assign w_unused_err_inject = bus.err_inject;
  assign r_armed             = 1'b0;
  assign r_err_ack           = 1'b0;
`endif

  assign bus.crc_out   = r_crc;
  assign bus.crc_ok    = r_ok;
  assign bus.crc_rdy   = r_rdy;
  assign bus.dword_cnt = r_cnt;
  assign bus.err_ack   = r_err_ack;

endmodule

// File: tb/tb_sata_rx_crc32_check.sv
// tb/tb_sata_rx_crc32_check.sv - self-checking bench for sata_rx_crc32_check
module tb_sata_rx_crc32_check;

  logic clk_75m = 1'b0;
  logic host_rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_75m = ~clk_75m;

  sata_rx_crc32_check_if u_if();

  sata_rx_crc32_check dut (
    .clk_75m    (clk_75m),
    .host_rst_n (host_rst_n),
    .bus        (u_if)
  );

  localparam logic [31:0] SEED = 32'h5232_5032;

  // Reference state
  logic [31:0] m_crc;
  logic        m_ok;
  logic        m_rdy;
  int          m_cnt;
  logic        m_armed;
  logic        m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // CRC as polynomial remainder: ((crc ^ data) * x^32) mod P by long division.
  function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [31:0] data);
    logic [63:0] v;
    logic [63:0] p;
    p = 64'h0000_0001_04C1_1DB7;
    v = {crc ^ data, 32'h0};
    for (int b = 63; b >= 32; b--) begin
      if (v[b]) v = v ^ (p << (b - 32));
    end
    return v[31:0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".crc_out"},   u_if.crc_out, m_crc);
    check({tag, ".crc_ok"},    {31'h0, u_if.crc_ok}, {31'h0, m_ok});
    check({tag, ".crc_rdy"},   {31'h0, u_if.crc_rdy}, {31'h0, m_rdy});
    check({tag, ".dword_cnt"}, {16'h0, u_if.dword_cnt}, m_cnt[31:0]);
    check({tag, ".err_ack"},   {31'h0, u_if.err_ack}, {31'h0, m_ack});
  endtask

  // Apply one cycle of inputs, advance the reference, optionally compare.
  task automatic step(input logic rst_n, input logic c_rst, input logic dv,
                      input logic [31:0] d, input logic inj, input bit do_chk,
                      input string tag);
    logic [31:0] pre;
    host_rst_n      = rst_n;
    u_if.crc_rst    = c_rst;
    u_if.data_valid = dv;
    u_if.data_in    = d;
    u_if.err_inject = inj;
    @(posedge clk_75m);
    #1;
    if (!rst_n) begin
      m_crc = SEED; m_ok = 0; m_rdy = 0; m_cnt = 0; m_armed = 0; m_ack = 0;
    end else if (c_rst) begin
      m_crc = SEED; m_ok = 0; m_rdy = 0; m_cnt = 0;
`ifdef SATA_RX_CRC_FAKE_ERR_EN
      m_armed = inj; m_ack = inj;
`else
      m_armed = 0; m_ack = 0;
`endif
    end else begin
      m_ack = 0;
      if (dv) begin
        pre   = m_crc;
        m_ok  = (pre == d) && !m_armed;
        m_crc = ref_crc(pre, d);
        m_rdy = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (do_chk) check_all(tag);
  endtask

  initial begin
    logic [31:0] d;
    int          len;

    // Reset state
    step(0, 0, 0, 32'h0, 0, 1, "reset");
    check("reset.seed", u_if.crc_out, SEED);

    // Data while idle is processed from the reset seed
    step(1, 0, 1, SEED, 0, 1, "idle_valid");
    check("idle_valid.ok", {31'h0, u_if.crc_ok}, 32'h1);

    // Seed dword matches itself
    step(1, 1, 0, 32'h0, 0, 1, "f1.rst");
    step(1, 0, 1, SEED, 0, 1, "f1.d0");
    check("f1.crc_zero", u_if.crc_out, 32'h0);
    check("f1.cnt1", {16'h0, u_if.dword_cnt}, 32'd1);

    // Single-bit difference yields the polynomial
    step(1, 1, 0, 32'h0, 0, 1, "f2.rst");
    step(1, 0, 1, 32'h5232_5033, 0, 1, "f2.d0");
    check("f2.poly", u_if.crc_out, 32'h04C1_1DB7);
    step(1, 0, 0, 32'hDEAD_BEEF, 0, 1, "f2.idle");
    step(1, 0, 1, 32'h04C1_1DB7, 0, 1, "f2.d1");
    check("f2.ok", {31'h0, u_if.crc_ok}, 32'h1);
    check("f2.cnt2", {16'h0, u_if.dword_cnt}, 32'd2);

    // Seed then zero, then crc_rst clears
    step(1, 1, 0, 32'h0, 0, 1, "f3.rst");
    step(1, 0, 1, SEED, 0, 1, "f3.d0");
    step(1, 0, 1, 32'h0, 0, 1, "f3.d1");
    check("f3.ok", {31'h0, u_if.crc_ok}, 32'h1);
    step(1, 1, 0, 32'h0, 0, 1, "f3.rst2");
    check("f3.rst_seed", u_if.crc_out, SEED);

    // crc_rst wins over a simultaneous dword
    step(1, 0, 1, 32'hCAFE_F00D, 0, 1, "f4.pre");
    step(1, 1, 1, 32'h1234_5678, 0, 1, "f4.collide");
    check("f4.seed", u_if.crc_out, SEED);
    check("f4.cnt0", {16'h0, u_if.dword_cnt}, 32'd0);

    // Injection request: acknowledged and forces crc_ok low only when compiled in
    step(1, 1, 0, 32'h0, 1, 1, "inj.rst");
`ifdef SATA_RX_CRC_FAKE_ERR_EN
    check("inj.ack", {31'h0, u_if.err_ack}, 32'h1);
`else
    check("inj.noack", {31'h0, u_if.err_ack}, 32'h0);
`endif
    step(1, 0, 1, SEED, 0, 1, "inj.d0");
    check("inj.ack_clear", {31'h0, u_if.err_ack}, 32'h0);
    step(1, 0, 1, ref_crc(SEED, SEED), 0, 1, "inj.d1");
    step(1, 1, 0, 32'h0, 0, 1, "inj.rst2");
    step(1, 0, 1, SEED, 0, 1, "inj.d2");
    check("inj.ok_after", {31'h0, u_if.crc_ok}, 32'h1);

    // Mid-frame reset aborts the frame
    step(1, 1, 0, 32'h0, 1, 1, "mr.rst");
    step(1, 0, 1, 32'h1111_2222, 0, 1, "mr.d0");
    step(1, 0, 1, 32'h3333_4444, 0, 1, "mr.d1");
    step(0, 0, 1, 32'h5555_6666, 1, 1, "mr.hostrst");
    check("mr.seed", u_if.crc_out, SEED);
    check("mr.cnt", {16'h0, u_if.dword_cnt}, 32'd0);
    step(1, 0, 1, SEED, 0, 1, "mr.after");
    check("mr.ok_disarmed", {31'h0, u_if.crc_ok}, 32'h1);

    // Randomized frames: gaps, collisions, good/bad CRC tails, stray resets
    for (int f = 0; f < 300; f++) begin
      step($urandom_range(0, 49) != 0, 1, $urandom_range(0, 3) == 0, $urandom,
           $urandom_range(0, 3) == 0, 1, "rnd.rst");
      len = $urandom_range(0, 12);
      for (int k = 0; k < len; k++) begin
        step(1, 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), 1, "rnd.d");
      end
      d = ($urandom_range(0, 3) != 0) ? m_crc : m_crc ^ (32'h1 << $urandom_range(0, 31));
      step(1, 0, 1, d, 0, 1, "rnd.tail");
    end

    // Long frame: counter saturates, CRC keeps running
    step(1, 1, 0, 32'h0, 0, 1, "long.rst");
    for (int k = 0; k < 70000; k++) begin
      step(1, 0, 1, $urandom, 0, (k % 8192) == 0, "long.d");
    end
    check_all("long.end");
    check("long.sat", {16'h0, u_if.dword_cnt}, 32'h0000_FFFF);
    step(1, 0, 1, m_crc, 0, 1, "long.tail");
    check("long.tail_ok", {31'h0, u_if.crc_ok}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sata_rx_crc32_check.md
SATA_RX_CRC32_CHECK -- requirements
Module: sata_rx_crc32_check

Interface
REQ-001 SHALL have port clk_75m, input, 1 bit: the single clock; all logic on its rising edge.
REQ-002 SHALL have port host_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port crc_rst, input, 1 bit: start-of-frame pulse that re-seeds the CRC.
REQ-004 SHALL have port data_in, input, 32 bits: descrambled frame dword, the FIS payload followed by the CRC dword.
REQ-005 SHALL have port data_valid, input, 1 bit: data_in qualifier.
REQ-006 SHALL have port crc_out, output, 32 bits: running CRC over all dwords accepted since the last crc_rst.
REQ-007 SHALL have port crc_ok, output, 1 bit: the last accepted dword equalled the CRC of all dwords before it.
REQ-008 SHALL have port crc_rdy, output, 1 bit: at least one dword has been accepted since crc_rst.
REQ-009 SHALL have port dword_cnt, output, 16 bits: number of dwords accepted since crc_rst.
REQ-010 SHALL have port err_inject, input, 1 bit, and port err_ack, output, 1 bit; both are used only under SATA_RX_CRC_FAKE_ERR_EN.

Function
REQ-011 The CRC SHALL be the SATA CRC32:
- polynomial 0x04C11DB7, seed 0x52325032;
- dword processed MSB-first, one dword per cycle;
- no bit reflection, no final XOR.
REQ-012 Step rule, for each bit i from 31 down to 0: fb = crc[31] XOR data[i]; crc = (crc << 1) XOR (fb ? poly : 0). Equivalently, crc_next = ((crc XOR data) times x^32) mod P.
REQ-013 When data_valid=1 and crc_rst=0, crc_out SHALL take crc_next one cycle later. Otherwise crc_out SHALL hold.
REQ-014 On an accepted dword, crc_ok SHALL be registered as (crc_out before the update == data_in), and crc_rdy SHALL be set to 1, with the same 1-cycle latency.
REQ-015 crc_ok SHALL hold its value until the next accepted dword or crc_rst. The upstream link layer samples crc_ok at end of frame, so the final compare is against the CRC dword.
REQ-016 When crc_rst=1, the next cycle SHALL give: crc_out=0x52325032, crc_ok=0, crc_rdy=0, dword_cnt=0.
REQ-017 If crc_rst and data_valid are high in the same cycle, crc_rst SHALL win and the dword SHALL be discarded.
REQ-018 dword_cnt SHALL increment on each accepted dword and saturate at 0xFFFF with no wrap. crc_out SHALL keep updating after saturation.
REQ-019 data_valid while idle (no crc_rst seen since reset) SHALL be processed from the reset seed.

Reset
REQ-020 When host_rst_n=0 at a clock edge, the outputs SHALL be: crc_out=0x52325032, crc_ok=0, crc_rdy=0, dword_cnt=0, err_ack=0, injection disarmed.
REQ-021 Reset asserted mid-frame SHALL abort the frame. No output may reflect pre-reset data afterwards.

Configuration
REQ-022 With macro SATA_RX_CRC_FAKE_ERR_EN defined, fault injection SHALL be compiled in:
- err_inject=1 in a crc_rst cycle arms injection for that frame;
- err_ack SHALL pulse high for exactly one cycle, the cycle after arming;
- while armed, every crc_ok update SHALL be forced to 0;
- the arm SHALL clear on the next crc_rst without err_inject, or on reset.
REQ-023 Without SATA_RX_CRC_FAKE_ERR_EN: err_inject SHALL be ignored, err_ack SHALL be tied to 0, and no injection logic SHALL exist.

Structure
REQ-024 Package sata_crc_pkg SHALL hold CRC_POLY (0x04C11DB7), CRC_SEED (0x52325032), and the pure function crc32_step(crc, data) returning 32 bits.
REQ-025 There SHALL be one combinational sub-module, sata_crc32_next: inputs crc and data (32 bits each), output crc_next (32 bits), implemented with crc32_step. The top module holds all registers, the compare, the counter and the injection logic.

Verification
REQ-026 crc_rst, then data_in=0x52325032 valid -> crc_ok=1 (seed matches), crc_rdy=1, crc_out=0x00000000, dword_cnt=1.
REQ-027 crc_rst, then 0x52325033 -> crc_out=0x04C11DB7 and crc_ok=0. Then 0x04C11DB7 -> crc_ok=1 and dword_cnt=2.
REQ-028 crc_rst, then 0x52325032 and 0x00000000 -> crc_ok=1 after the second dword, crc_out=0x00000000. Then crc_rst -> crc_out=0x52325032, crc_ok=0, crc_rdy=0.
REQ-029 crc_rst and data_valid asserted together with data 0x12345678 -> dword discarded, crc_out=0x52325032, dword_cnt=0. A 70000-dword frame -> dword_cnt=0xFFFF.
REQ-030 Build with SATA_RX_CRC_FAKE_ERR_EN, run the REQ-026 frame with err_inject=1 at crc_rst -> err_ack high one cycle, crc_ok=0. Next frame without err_inject -> crc_ok=1.
REQ-031 host_rst_n=0 mid-frame -> all outputs at their REQ-020 values the next cycle.
